// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bin_to_bcd_seq_pkg
// Brief   : Shared constants and state encoding for the BCD converter and
//           the seven-segment display driver.
// Rev     : 1.0
// ============================================================================
package bin_to_bcd_seq_pkg;

    localparam int c_dl          = 4;
    localparam int c_num_digits  = 3;
    localparam int c_add3_thresh = 5;
    localparam int c_add3_val    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : bin_to_bcd_seq_if
// Brief   : Start/busy/done handshake plus value and digit bundle.
// Rev     : 1.0
// ============================================================================
interface bin_to_bcd_seq_if #(
    parameter int DL = 4,
    parameter int BW = 8
);
    logic [BW-1:0] full;
    logic          start;
    logic          busy;
    logic          done;
    logic [DL-1:0] ones;
    logic [DL-1:0] ten;
    logic [DL-1:0] hund;

    modport master (
        output full, start,
        input  busy, done, ones, ten, hund
    );

    modport slave (
        input  full, start,
        output busy, done, ones, ten, hund
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
`default_nettype none
// ============================================================================
// Module  : bcd_add3
// Brief   : Double-dabble nibble correction: adds 3 when the digit is >= 5.
// Rev     : 1.0
// ============================================================================
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int DL = c_dl
) (
    input  logic [DL-1:0] nib_in,
    output logic [DL-1:0] nib_out
);

    assign nib_out = (nib_in >= DL'(c_add3_thresh)) ? nib_in + DL'(c_add3_val) : nib_in;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin_to_bcd_seq
// Brief   : Sequential double-dabble binary-to-BCD converter, one bit/clock,
//           with held digit registers and a start/busy/done handshake.
// Rev     : 1.0
// ============================================================================
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int DL = c_dl,
    parameter int BW = 8
) (
    input  logic             CLK,
    input  logic             RST,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int SRW = c_num_digits * DL + BW;
    localparam int CW  = (BW > 1) ? $clog2(BW) : 1;

    state_t          r_state;
    logic [SRW-1:0]  r_sr;
    logic [SRW-1:0]  w_sr_fix;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [DL-1:0]   r_ones;
    logic [DL-1:0]   r_ten;
    logic [DL-1:0]   r_hund;

    // Binary part passes through; each BCD nibble is corrected before the shift.
    assign w_sr_fix[BW-1:0] = r_sr[BW-1:0];

    for (genvar i = 0; i < c_num_digits; i++) begin : g_add3
        bcd_add3 #(.DL(DL)) u_add3 (
            .nib_in  (r_sr[BW + i*DL +: DL]),
            .nib_out (w_sr_fix[BW + i*DL +: DL])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ones  <= '0;
            r_ten   <= '0;
            r_hund  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sr    <= {{(c_num_digits*DL){1'b0}}, bus.full};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sr  <= w_sr_fix << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(BW - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Digits change only here, so the display never sees partial sums.
                    r_ones  <= r_sr[BW +: DL];
                    r_ten   <= r_sr[BW + DL +: DL];
                    r_hund  <= r_sr[BW + 2*DL +: DL];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.ones = r_ones;
    assign bus.ten  = r_ten;
    assign bus.hund = r_hund;

endmodule
`default_nettype wire
